// File: rtl/button_event_scheduler_pkg.sv
// Shared event-type codes, channel FSM state encoding and width helpers
// for the button event scheduler.
package button_event_scheduler_pkg;

   localparam logic [1:0] EV_NONE    = 2'b00;
   localparam logic [1:0] EV_PRESS   = 2'b01;
   localparam logic [1:0] EV_RELEASE = 2'b10;
   localparam logic [1:0] EV_REPEAT  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HELD   = 2'd1,
      ST_REPEAT = 2'd2
   } ch_state_e;

   // Counter must hold the larger of the two terminal counts.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > 1) ? int'($clog2(m)) : 1;
   endfunction

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? int'($clog2(n)) : 1;
   endfunction

endpackage

// File: rtl/button_event_scheduler_channel_fsm.sv
// Per-button edge detect, press/hold/repeat FSM with counter, and a
// single-entry pending event slot feeding the shared arbiter.
module button_channel_fsm
   import button_event_scheduler_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES   = 62500000,
   parameter int unsigned REPEAT_CYCLES = 12500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       level,
   input  logic       grant,
   output logic       pend_valid,
   output logic [1:0] pend_type,
   output logic       drop_c
);

   localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   ch_state_e        state;
   logic [CNT_W-1:0] cnt;
   logic             prev;
   logic             rise;
   logic             fall;
   logic             post;
   logic [1:0]       post_type;

   assign rise = level & ~prev;
   assign fall = ~level & prev;

   // Event to post this cycle; release wins over a coincident repeat expiry.
   always_comb begin
      post      = 1'b0;
      post_type = EV_NONE;
      unique case (state)
         ST_IDLE: if (rise) begin
            post      = 1'b1;
            post_type = EV_PRESS;
         end
         ST_HELD: if (fall) begin
            post      = 1'b1;
            post_type = EV_RELEASE;
         end else if (cnt == HOLD_LAST) begin
            post      = 1'b1;
            post_type = EV_REPEAT;
         end
         ST_REPEAT: if (fall) begin
            post      = 1'b1;
            post_type = EV_RELEASE;
         end else if (cnt == REPEAT_LAST) begin
            post      = 1'b1;
            post_type = EV_REPEAT;
         end
         default: ;
      endcase
   end

   // A same-cycle grant frees the slot, so only an ungranted overwrite drops.
   assign drop_c = post & pend_valid & ~grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         prev       <= 1'b0;
         pend_valid <= 1'b0;
         pend_type  <= EV_NONE;
      end else begin
         prev <= level;
         unique case (state)
            ST_IDLE: if (rise) begin
               state <= ST_HELD;
               cnt   <= '0;
            end
            ST_HELD: if (fall) begin
               state <= ST_IDLE;
               cnt   <= '0;
            end else if (cnt == HOLD_LAST) begin
               state <= ST_REPEAT;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
            ST_REPEAT: if (fall) begin
               state <= ST_IDLE;
               cnt   <= '0;
            end else if (cnt == REPEAT_LAST) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
         if (post) begin
            pend_valid <= 1'b1;
            pend_type  <= post_type;
         end else if (grant) begin
            pend_valid <= 1'b0;
            pend_type  <= EV_NONE;
         end
      end
   end

endmodule

// File: rtl/button_event_scheduler.sv
// Button event scheduler: per-channel event generators merged onto one
// valid/ready event stream by a round-robin arbiter and output register.
module button_event_scheduler
   import button_event_scheduler_pkg::*;
#(
   parameter  int unsigned WIDTH         = 4,
   parameter  int unsigned HOLD_CYCLES   = 62500000,
   parameter  int unsigned REPEAT_CYCLES = 12500000,
   localparam int unsigned ID_W          = id_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] debounced,
   output logic             event_valid,
   input  logic             event_ready,
   output logic [ID_W-1:0]  event_id,
   output logic [1:0]       event_type,
   output logic             drop_flag
);

   logic [WIDTH-1:0] pend_valid;
   logic [WIDTH-1:0] grant;
   logic [WIDTH-1:0] drop_c;
   logic [1:0]       pend_type [WIDTH];
   logic             free_c;
   logic             gnt_found;
   logic [ID_W-1:0]  gnt_idx;
   logic [1:0]       gnt_type;
   logic [ID_W-1:0]  cand;
   logic [ID_W-1:0]  start_idx;

   for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      button_channel_fsm #(
         .HOLD_CYCLES   (HOLD_CYCLES),
         .REPEAT_CYCLES (REPEAT_CYCLES)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .level      (debounced[g]),
         .grant      (grant[g]),
         .pend_valid (pend_valid[g]),
         .pend_type  (pend_type[g]),
         .drop_c     (drop_c[g])
      );
      assign grant[g] = free_c & gnt_found & (gnt_idx == ID_W'(g));
   end

   assign free_c = ~event_valid | event_ready;

   // First pending channel at or after start_idx, wrapping at WIDTH-1.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      gnt_type  = EV_NONE;
      cand      = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cand = ID_W'((32'(start_idx) + i) % WIDTH);
         if (!gnt_found && pend_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
            gnt_type  = pend_type[cand];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         event_valid <= 1'b0;
         event_id    <= '0;
         event_type  <= EV_NONE;
         start_idx   <= '0;
         drop_flag   <= 1'b0;
      end else begin
         drop_flag <= drop_flag | (|drop_c);
         if (free_c) begin
            event_valid <= gnt_found;
            if (gnt_found) begin
               event_id   <= gnt_idx;
               event_type <= gnt_type;
               start_idx  <= (gnt_idx == ID_W'(WIDTH - 1)) ? '0 : gnt_idx + ID_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_button_event_scheduler.sv
// Randomized and directed bench for button_event_scheduler, checked each
// cycle against an age-based behavioural model of the event stream.
module tb_button_event_scheduler;
   import button_event_scheduler_pkg::*;

   localparam int W    = 4;
   localparam int HOLD = 8;
   localparam int REP  = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] debounced = '0;
   logic         event_ready = 1'b0;
   logic         event_valid;
   logic [1:0]   event_id;
   logic [1:0]   event_type;
   logic         drop_flag;

   always #5 clk = ~clk;

   button_event_scheduler #(
      .WIDTH         (W),
      .HOLD_CYCLES   (HOLD),
      .REPEAT_CYCLES (REP)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .debounced   (debounced),
      .event_valid (event_valid),
      .event_ready (event_ready),
      .event_id    (event_id),
      .event_type  (event_type),
      .drop_flag   (drop_flag)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Model: each held button has an age (edges since its press); repeats
   // fall at age HOLD, HOLD+REP, ... Slots and round-robin at event level.
   bit m_prev [W];
   int m_age  [W];
   bit m_pend [W];
   int m_ptype[W];
   bit m_valid;
   int m_id, m_type, m_start;
   bit m_drop;

   typedef struct {int id; int typ; int cyc;} ev_t;
   ev_t log_q[$];

   task automatic model_reset();
      for (int c = 0; c < W; c++) begin
         m_prev[c] = 0; m_age[c] = 0; m_pend[c] = 0; m_ptype[c] = 0;
      end
      m_valid = 0; m_id = 0; m_type = 0; m_start = 0; m_drop = 0;
   endtask

   task automatic model_step();
      bit free;
      int g, c, p_type;
      bit lvl;
      free = !m_valid || event_ready;
      g = -1;
      if (free) begin
         for (int i = 0; i < W; i++) begin
            c = (m_start + i) % W;
            if (g < 0 && m_pend[c]) g = c;
         end
         if (g >= 0) begin
            m_valid = 1; m_id = g; m_type = m_ptype[g]; m_start = (g + 1) % W;
         end else begin
            m_valid = 0;
         end
      end
      for (int k = 0; k < W; k++) begin
         lvl = debounced[k];
         p_type = 0;
         if (lvl && !m_prev[k]) begin
            p_type = int'(EV_PRESS); m_age[k] = 0;
         end else if (!lvl && m_prev[k]) begin
            p_type = int'(EV_RELEASE);
         end else if (lvl) begin
            m_age[k]++;
            if (m_age[k] >= HOLD && (m_age[k] - HOLD) % REP == 0) p_type = int'(EV_REPEAT);
         end
         if (p_type != 0) begin
            if (m_pend[k] && k != g) m_drop = 1;
            m_pend[k] = 1; m_ptype[k] = p_type;
         end else if (k == g) begin
            m_pend[k] = 0;
         end
         m_prev[k] = lvl;
      end
   endtask

   task automatic cycle();
      if (event_valid && event_ready)
         log_q.push_back('{int'(event_id), int'(event_type), cyc});
      @(posedge clk);
      cyc++;
      if (!rst_n) model_reset();
      else model_step();
      #1;
      chk("valid", 32'(event_valid), 32'(m_valid));
      if (m_valid) begin
         chk("id", 32'(event_id), 32'(m_id));
         chk("type", 32'(event_type), 32'(m_type));
      end
      chk("drop_flag", 32'(drop_flag), 32'(m_drop));
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      run(2);
      rst_n = 1'b1;
      log_q.delete();
   endtask

   function automatic int log_id(input int i);
      return (i < log_q.size()) ? log_q[i].id : -1;
   endfunction
   function automatic int log_typ(input int i);
      return (i < log_q.size()) ? log_q[i].typ : -1;
   endfunction
   function automatic int log_cyc(input int i);
      return (i < log_q.size()) ? log_q[i].cyc : -1000;
   endfunction

   initial begin
      model_reset();
      run(2);
      chk("rst_valid", 32'(event_valid), 32'd0);
      chk("rst_id", 32'(event_id), 32'd0);
      chk("rst_type", 32'(event_type), 32'd0);
      chk("rst_drop", 32'(drop_flag), 32'd0);
      rst_n = 1'b1;

      // Short pulse on ch2: press then release, no repeat.
      log_q.delete();
      event_ready = 1'b1;
      debounced[2] = 1'b1; run(3);
      debounced[2] = 1'b0; run(6);
      chk("pulse_n", 32'(log_q.size()), 32'd2);
      chk("pulse_id0", 32'(log_id(0)), 32'd2);
      chk("pulse_t0", 32'(log_typ(0)), 32'(EV_PRESS));
      chk("pulse_id1", 32'(log_id(1)), 32'd2);
      chk("pulse_t1", 32'(log_typ(1)), 32'(EV_RELEASE));

      // Long hold on ch0: press, repeats at +8, +12, +16, release.
      do_reset();
      event_ready = 1'b1;
      debounced[0] = 1'b1; run(20);
      debounced[0] = 1'b0; run(6);
      chk("hold_n", 32'(log_q.size()), 32'd5);
      chk("hold_t0", 32'(log_typ(0)), 32'(EV_PRESS));
      for (int i = 1; i <= 3; i++) chk("hold_trep", 32'(log_typ(i)), 32'(EV_REPEAT));
      chk("hold_t4", 32'(log_typ(4)), 32'(EV_RELEASE));
      chk("hold_gap1", 32'(log_cyc(1) - log_cyc(0)), 32'd8);
      chk("hold_gap2", 32'(log_cyc(2) - log_cyc(1)), 32'd4);
      chk("hold_gap3", 32'(log_cyc(3) - log_cyc(2)), 32'd4);

      // All four pressed together: ids 0..3 on consecutive cycles.
      do_reset();
      event_ready = 1'b1;
      debounced = 4'hF; run(8);
      chk("all_n", 32'(log_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("all_id", 32'(log_id(i)), 32'(i));
         chk("all_t", 32'(log_typ(i)), 32'(EV_PRESS));
         chk("all_cyc", 32'(log_cyc(i) - log_cyc(0)), 32'(i));
      end
      debounced = '0; run(8);

      // Stalled consumer: ch1 release overwrites pending ch1 press.
      do_reset();
      event_ready = 1'b0;
      debounced[0] = 1'b1; run(3);
      debounced[1] = 1'b1; run(2);
      debounced[1] = 1'b0; run(5);
      chk("stall_drop", 32'(drop_flag), 32'd1);
      chk("stall_id", 32'(event_id), 32'd0);
      event_ready = 1'b1; run(3);
      debounced[0] = 1'b0; run(6);
      chk("stall_id0", 32'(log_id(0)), 32'd0);
      chk("stall_id1", 32'(log_id(1)), 32'd1);
      chk("stall_t1", 32'(log_typ(1)), 32'(EV_RELEASE));

      // Reset mid-handshake with ch3 held, then press re-reported.
      do_reset();
      event_ready = 1'b0;
      debounced[3] = 1'b1; run(3);
      chk("mid_valid_pre", 32'(event_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_valid", 32'(event_valid), 32'd0);
      chk("mid_id", 32'(event_id), 32'd0);
      chk("mid_type", 32'(event_type), 32'd0);
      chk("mid_drop", 32'(drop_flag), 32'd0);
      model_reset();
      run(1);
      rst_n = 1'b1;
      event_ready = 1'b1;
      log_q.delete();
      run(4);
      chk("mid_id3", 32'(log_id(0)), 32'd3);
      chk("mid_t3", 32'(log_typ(0)), 32'(EV_PRESS));
      debounced = '0; run(4);

      // Random toggling and back-pressure, with a mid-run reset.
      for (int r = 0; r < 2; r++) begin
         do_reset();
         for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < W; c++)
               if ($urandom_range(0, 9) == 0) debounced[c] = ~debounced[c];
            event_ready = (n % 300 < 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
            cycle();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
